regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_sb.sv | 102 ++++++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Provides default widths, the register address type and the zero register.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: issue sets, write-back clears, flush clears all.
// Ports: clk, rst (async active-low), iss_en/iss_rd, wr_en/wr_addr, flush -> busy, iss_ok.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic             iss_ok
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  assign busy   = busy_q;
  assign iss_ok = !busy_q[iss_rd];

  // Priority per entry: flush, then set, then clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (flush)
        busy_d[i] = 1'b0;
      else if (iss_en && iss_ok && iss_rd == AW'(i))
        busy_d[i] = 1'b1;
      else if (wr_en && wr_addr == AW'(i))
        busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with scoreboard, registered 2-port read and 1 write port.
// Ports: clk, rst, rd_req/rs1/rs2 -> rs1_data/rs2_data/rd_vld/hazard,
// iss_en/iss_rd -> iss_ok, wr_en/wr_addr/wr_data, flush.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_vld,
  output logic            hazard,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ok,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_live;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_go;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .busy    (busy),
    .iss_ok  (iss_ok)
  );

  assign wr_live = wr_en && (wr_addr != AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs1_busy = busy[rs1] && !(wr_live && wr_addr == rs1);
    rs2_busy = busy[rs2] && !(wr_live && wr_addr == rs2);
    rs1_val  = regs[rs1];
    rs2_val  = regs[rs2];
    if (wr_live && wr_addr == rs1) rs1_val = wr_data;
    if (wr_live && wr_addr == rs2) rs2_val = wr_data;
  end
`else
  // A register being written this cycle stalls reads until the edge.
  always_comb begin
    rs1_busy = busy[rs1] || (wr_live && wr_addr == rs1);
    rs2_busy = busy[rs2] || (wr_live && wr_addr == rs2);
    rs1_val  = regs[rs1];
    rs2_val  = regs[rs2];
  end
`endif

  assign hazard = rd_req && (rs1_busy || rs2_busy);
  assign rd_go  = rd_req && !hazard;

  // regs[0] is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rd_vld   <= 1'b0;
    end else begin
      rd_vld <= rd_go;
      if (rd_go) begin
        rs1_data <= rs1_val;
        rs2_data <= rs2_val;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
// Covers read path, scoreboard stalls, issue conflicts, x0, flush, reset.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic            clk;
  logic            rst;
  logic            rd_req;
  reg_addr_t       rs1;
  reg_addr_t       rs2;
  logic [31:0]     rs1_data;
  logic [31:0]     rs2_data;
  logic            rd_vld;
  logic            hazard;
  logic            iss_en;
  reg_addr_t       iss_rd;
  logic            iss_ok;
  logic            wr_en;
  reg_addr_t       wr_addr;
  logic [31:0]     wr_data;
  logic            flush;

  int errors = 0;
  int checks = 0;

  regfile_sb #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_vld   (rd_vld),
    .hazard   (hazard),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .iss_ok   (iss_ok),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    rd_req = 0; rs1 = 0; rs2 = 0;
    iss_en = 0; iss_rd = 0;
    wr_en  = 0; wr_addr = 0; wr_data = 0;
    flush  = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_vld", 32'(rd_vld), 32'd0);
    chk("rst_rs1", rs1_data, 32'h0);
    chk("rst_rs2", rs2_data, 32'h0);
    #10 rst = 1'b1;
    tick();

    // write then read
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 0;
    rd_req = 1; rs1 = 5; rs2 = 0;
    #1 chk("wr_rd_haz", 32'(hazard), 32'd0);
    tick();
    rd_req = 0;
    chk("wr_rd_vld", 32'(rd_vld), 32'd1);
    chk("wr_rd_rs1", rs1_data, 32'hDEADBEEF);
    chk("wr_rd_rs2", rs2_data, 32'h0);
    tick();
    chk("idle_vld", 32'(rd_vld), 32'd0);
    chk("idle_hold", rs1_data, 32'hDEADBEEF);

    // scoreboard stall on x7
    iss_en = 1; iss_rd = 7;
    #1 chk("iss7_ok", 32'(iss_ok), 32'd1);
    tick();
    iss_en = 0;
    rd_req = 1; rs1 = 7; rs2 = 0;
    #1 chk("stall_haz", 32'(hazard), 32'd1);
    tick();
    chk("stall_vld", 32'(rd_vld), 32'd0);
    wr_en = 1; wr_addr = 7; wr_data = 32'h12;
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp_haz", 32'(hazard), 32'd0);
    tick();
    wr_en = 0; rd_req = 0;
    chk("byp_vld", 32'(rd_vld), 32'd1);
    chk("byp_rs1", rs1_data, 32'h12);
`else
    #1 chk("nobyp_haz", 32'(hazard), 32'd1);
    tick();
    wr_en = 0;
    chk("nobyp_vld0", 32'(rd_vld), 32'd0);
    #1 chk("nobyp_haz2", 32'(hazard), 32'd0);
    tick();
    rd_req = 0;
    chk("nobyp_vld", 32'(rd_vld), 32'd1);
    chk("nobyp_rs1", rs1_data, 32'h12);
`endif
    tick();

    // issue conflict and set-wins
    iss_en = 1; iss_rd = 3;
    tick();
    wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    #1 chk("conf_ok", 32'(iss_ok), 32'd0);
    tick();
    iss_en = 0; wr_en = 0;
    #1 chk("conf_freed", 32'(iss_ok), 32'd1);
    iss_en = 1; iss_rd = 3;
    wr_en = 1; wr_addr = 3; wr_data = 32'h44;
    #1 chk("setwin_ok", 32'(iss_ok), 32'd1);
    tick();
    iss_en = 0; wr_en = 0;
    rd_req = 1; rs1 = 3; rs2 = 0;
    #1 chk("setwin_busy", 32'(iss_ok), 32'd0);
    chk("setwin_haz", 32'(hazard), 32'd1);
    rd_req = 0;
    wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    tick();
    wr_en = 0;

    // zero register
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    iss_en = 1; iss_rd = 0;
    #1 chk("x0_iss_ok", 32'(iss_ok), 32'd1);
    tick();
    wr_en = 0; iss_en = 0;
    rd_req = 1; rs1 = 0; rs2 = 0;
    #1 chk("x0_haz", 32'(hazard), 32'd0);
    chk("x0_ok2", 32'(iss_ok), 32'd1);
    tick();
    rd_req = 0;
    chk("x0_vld", 32'(rd_vld), 32'd1);
    chk("x0_rs1", rs1_data, 32'h0);
    chk("x0_rs2", rs2_data, 32'h0);

    // flush
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1; wr_addr = reg_addr_t'(i); wr_data = 32'(i * 32'h11);
      tick();
    end
    wr_en = 0;
    for (int i = 1; i <= 4; i++) begin
      iss_en = 1; iss_rd = reg_addr_t'(i);
      tick();
    end
    rd_req = 1; rs1 = 1; rs2 = 4;
    iss_rd = 6; flush = 1;
    #1 chk("fl_haz_pre", 32'(hazard), 32'd1);
    tick();
    flush = 0; iss_en = 0;
    #1 chk("fl_haz14", 32'(hazard), 32'd0);
    chk("fl_x6_free", 32'(iss_ok), 32'd1);
    tick();
    chk("fl_vld", 32'(rd_vld), 32'd1);
    chk("fl_rs1", rs1_data, 32'h11);
    chk("fl_rs2", rs2_data, 32'h44);
    rs1 = 2; rs2 = 3;
    #1 chk("fl_haz23", 32'(hazard), 32'd0);
    tick();
    chk("fl_x2", rs1_data, 32'h22);
    chk("fl_x3", rs2_data, 32'h33);

    // reset mid-read
    rs1 = 5; rs2 = 1;
    tick();
    chk("pre_rst_rs1", rs1_data, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    chk("mid_rst_rs1", rs1_data, 32'h0);
    chk("mid_rst_vld", 32'(rd_vld), 32'd0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_vld", 32'(rd_vld), 32'd1);
    chk("post_rst_x5", rs1_data, 32'h0);
    chk("post_rst_x1", rs2_data, 32'h0);
    rs1 = 7; rs2 = 3;
    #1 chk("post_rst_haz", 32'(hazard), 32'd0);
    tick();
    rd_req = 0;
    chk("post_rst_x7", rs1_data, 32'h0);
    chk("post_rst_x3", rs2_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
